// File: rtl/uart_rx_hex_display_pkg.sv
// Shared definitions for the RX-FIFO hex parser: ASCII bounds, FSM states,
// segment patterns and the byte classifier.
package uart_rx_hex_display_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_DECODE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CLS_HEX    = 2'd0,
        CLS_IGNORE = 2'd1,
        CLS_CLEAR  = 2'd2,
        CLS_ERROR  = 2'd3
    } byte_class_e;

    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_ESC     = 8'h1B;
    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_9       = 8'h39;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_F = 8'h46;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_F = 8'h66;

    localparam logic [0:6] SEG_DASH  = 7'b1111110;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic is_letter(input logic [7:0] b);
        return ((b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_F)) ||
               ((b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_F));
    endfunction

    function automatic byte_class_e classify(input logic [7:0] b);
        if (is_digit(b) || is_letter(b)) return CLS_HEX;
        if ((b == ASCII_CR) || (b == ASCII_LF)) return CLS_IGNORE;
        if (b == ASCII_ESC) return CLS_CLEAR;
        return CLS_ERROR;
    endfunction

    // Letters of either case share the low nibble 1..6, so +9 gives A..F.
    function automatic logic [3:0] hex_nibble(input logic [7:0] b);
        if (is_digit(b)) return b[3:0];
        return 4'(b[3:0] + 4'd9);
    endfunction

endpackage

// File: rtl/uart_rx_hex_display_if.sv
// RX FIFO read port: head byte, empty flag and pop strobe.
interface uart_rx_hex_display_if;
    logic       rx_empty;
    logic [7:0] read_data;
    logic       read_uart;

    modport master (output rx_empty, output read_data, input read_uart);
    modport slave  (input rx_empty, input read_data, output read_uart);
endinterface

// File: rtl/uart_rx_hex_display_hex_to_7seg.sv
// Combinational nibble to active-low 7-segment pattern, bit order a..g.
module uart_rx_hex_display_hex_to_7seg (
    input  logic [3:0] nibble,
    output logic [0:6] seg
);

    always_comb begin
        unique case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/uart_rx_hex_display.sv
// Pops RX FIFO bytes, shifts hex digits into a 16-bit value and shows it on a
// 4-digit multiplexed 7-segment display; non-hex bytes show dashes.
module uart_rx_hex_display
    import uart_rx_hex_display_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    uart_rx_hex_display_if.slave    fifo,
    output logic [15:0]             value,
    output logic                    err,
    output logic [3:0]              an,
    output logic [0:6]              seg
);

    state_e                  state_q, state_d;
    logic [7:0]              byte_q, byte_d;
    logic [15:0]             value_q, value_d;
    logic                    err_q, err_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [3:0]              an_q, an_d;
    logic [0:6]              seg_q, seg_d;

    logic       pop;
    logic [1:0] sel;
    logic [3:0] digit;
    logic [0:6] seg_hex;

    assign pop = (state_q == ST_IDLE) & ~fifo.rx_empty & ~reset;
    assign sel = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        unique case (sel)
            2'd0: digit = value_q[3:0];
            2'd1: digit = value_q[7:4];
            2'd2: digit = value_q[11:8];
            default: digit = value_q[15:12];
        endcase
    end

    uart_rx_hex_display_hex_to_7seg u_hex_to_7seg (
        .nibble (digit),
        .seg    (seg_hex)
    );

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        value_d   = value_q;
        err_d     = err_q;
        refresh_d = refresh_q + REFRESH_BITS'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    byte_d  = fifo.read_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                unique case (classify(byte_q))
                    CLS_HEX: begin
                        value_d = {value_q[11:0], hex_nibble(byte_q)};
                        err_d   = 1'b0;
                    end
                    CLS_IGNORE: ;
                    CLS_CLEAR: begin
                        value_d = 16'h0000;
                        err_d   = 1'b0;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (sel)
            2'd0: an_d = 4'b1110;
            2'd1: an_d = 4'b1101;
            2'd2: an_d = 4'b1011;
            default: an_d = 4'b0111;
        endcase
        seg_d = err_q ? SEG_DASH : seg_hex;
    end

    // A reset while decoding drops byte_q; the pop already happened so the
    // byte is simply lost.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            byte_q    <= 8'h00;
            value_q   <= 16'h0000;
            err_q     <= 1'b0;
            refresh_q <= '0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            value_q   <= value_d;
            err_q     <= err_d;
            refresh_q <= refresh_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign fifo.read_uart = pop;
    assign value          = value_q;
    assign err            = err_q;
    assign an             = an_q;
    assign seg            = seg_q;

endmodule

// File: tb/tb_uart_rx_hex_display.sv
// Directed bench: a queue models the RX FIFO, checks are immediate assertions.
module tb_uart_rx_hex_display;

    logic        clk_100MHz = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value;
    logic        err;
    logic [3:0]  an;
    logic [0:6]  seg;

    uart_rx_hex_display_if fif ();

    uart_rx_hex_display #(.REFRESH_BITS(4)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .fifo       (fif),
        .value      (value),
        .err        (err),
        .an         (an),
        .seg        (seg)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    logic [7:0] q[$];
    int         pops = 0;
    int         adj = 0;
    logic       pend = 1'b0;
    int         pass_cnt = 0;
    int         fail_cnt = 0;
    int         total = 0;

    // FIFO model: a pop sampled before an edge removes the head at the next negedge.
    always @(negedge clk_100MHz) begin
        if (pend) begin
            if (q.size() > 0) void'(q.pop_front());
            pops++;
        end
        fif.rx_empty  = (q.size() == 0);
        fif.read_data = (q.size() > 0) ? q[0] : 8'h00;
        #1;
        if (fif.read_uart && pend) adj++;
        pend = fif.read_uart;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_100MHz);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk("drain", 16'(q.size() == 0), 16'd1);
    endtask

    logic [3:0] exp_an[4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [0:6] exp_seg[4] = '{7'b0000110, 7'b0111000, 7'b0001000, 7'b1001111};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        reset = 1'b1;
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        #2;
        chk("rst_read_uart", 16'(fif.read_uart), 16'd0);
        chk("rst_value", value, 16'h0000);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_an", 16'(an), 16'(4'b1111));
        chk("rst_seg", 16'(seg), 16'(7'b1111111));

        @(negedge clk_100MHz);
        reset = 1'b0;
        tick();
        chk("post_rst_an", 16'(an), 16'(4'b1110));
        chk("post_rst_seg", 16'(seg), 16'(7'b0000001));

        // "1Af3"
        pops = 0; adj = 0;
        q.push_back(8'h31); q.push_back(8'h41); q.push_back(8'h66); q.push_back(8'h33);
        drain();
        chk("t2_pops", 16'(pops), 16'd4);
        chk("t2_adjacent", 16'(adj), 16'd0);
        chk("t2_value", value, 16'h1AF3);
        chk("t2_err", 16'(err), 16'd0);

        n = 0;
        while (an == 4'b1110 && n < 40) begin tick(); n++; end
        while (an != 4'b1110 && n < 40) begin tick(); n++; end
        chk("disp_align", 16'(an == 4'b1110), 16'd1);
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("disp_an_d%0d_c%0d", d, k), 16'(an), 16'(exp_an[d]));
                chk($sformatf("disp_seg_d%0d_c%0d", d, k), 16'(seg), 16'(exp_seg[d]));
                tick();
            end
        end

        // "12345": leading '1' shifted out
        for (int i = 1; i <= 5; i++) q.push_back(8'(8'h30 + i));
        drain();
        chk("t3_value", value, 16'h2345);

        q.push_back(8'h47);
        drain();
        chk("t4_err", 16'(err), 16'd1);
        chk("t4_value", value, 16'h2345);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t4_dash_c%0d", k), 16'(seg), 16'(7'b1111110));
            tick();
        end
        q.push_back(8'h37);
        drain();
        chk("t4b_err", 16'(err), 16'd0);
        chk("t4b_value", value, 16'h3457);

        pops = 0;
        q.push_back(8'h0D); q.push_back(8'h0A);
        drain();
        chk("t5_pops", 16'(pops), 16'd2);
        chk("t5_value", value, 16'h3457);
        chk("t5_err", 16'(err), 16'd0);
        q.push_back(8'h1B);
        drain();
        chk("t5_esc_value", value, 16'h0000);
        chk("t5_esc_err", 16'(err), 16'd0);

        q.push_back(8'h61);
        drain();
        chk("t6_pre_value", value, 16'h000A);

        // Reset while '5' is being decoded: it must vanish without a re-pop
        pops = 0;
        q.push_back(8'h35); q.push_back(8'h36);
        n = 0;
        while (!fif.read_uart && n < 50) begin tick(); n++; end
        chk("t6_pop_seen", 16'(fif.read_uart), 16'd1);
        @(negedge clk_100MHz);
        reset = 1'b1;
        @(negedge clk_100MHz);
        #2;
        chk("t6_rst_value", value, 16'h0000);
        chk("t6_rst_read_uart", 16'(fif.read_uart), 16'd0);
        @(negedge clk_100MHz);
        reset = 1'b0;
        #2;
        drain();
        chk("t6_pops", 16'(pops), 16'd2);
        chk("t6_value", value, 16'h0006);
        chk("t6_err", 16'(err), 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
